// File: rtl/kernel_coef_bank.sv
// kernel_coef_bank
//
// Multi-bank, host-writable store of convolution kernel coefficients for the
// D8M video filter path. It holds NBANK kernels of 5x5 coefficients each.
// Bank 0 powers up holding the 5x5 Gaussian kernel and the other banks power
// up as zero. On an accepted start, one bank is streamed over a valid/ready
// interface in raster order, either as the full 5x5 kernel or as its centre
// 3x3 window.
//
// Configuration macro: COEF_SUM_EN. When it is defined, a running sum of the
// streamed coefficients is presented on sum_out/sum_valid. When it is not
// defined, both outputs are tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   wr_en/wr_bank/    host write port; the write lands one cycle later
//   wr_addr/wr_data   (wr_addr = row*5+col)
//   wr_err            one-cycle pulse when a write was dropped
//   start/rd_bank/    stream request; rd_bank and ksize are latched when the
//   ksize             start is accepted (ksize: 0 = 3x3 centre, 1 = 5x5)
//   busy              high from an accepted start until the final handshake
//   coef_valid/ready  output handshake
//   coef_data/row/col coefficient and its kernel-relative position
//   coef_last         marks the final coefficient of the kernel
//   sum_out/sum_valid sum of the streamed kernel (COEF_SUM_EN builds only)
module kernel_coef_bank #(
  parameter  int COEF_W = 8,
  parameter  int NBANK  = 4,
  localparam int BANK_W = $clog2(NBANK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [4:0]        wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic              ksize,
  output logic              busy,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [2:0]        coef_row,
  output logic [2:0]        coef_col,
  output logic              coef_last,
  output logic [COEF_W+4:0] sum_out,
  output logic              sum_valid
);

  localparam int MEM_W = NBANK * 25 * COEF_W;
  localparam int AW    = $clog2(MEM_W);

  typedef enum logic {IDLE, RUN} state_e;

  // The Gaussian weight depends only on the distance from the kernel centre.
  function automatic int gauss_coef(input int a);
    int dr;
    int dc;
    dr = a / 5 - 2;
    dc = a % 5 - 2;
    if (dr < 0) dr = -dr;
    if (dc < 0) dc = -dc;
    case (dr * 3 + dc)
      0:       return 32;
      1:       return 19;
      2:       return 4;
      3:       return 19;
      4:       return 12;
      5:       return 3;
      6:       return 4;
      7:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [MEM_W-1:0] mem_init();
    logic [MEM_W-1:0] m;
    m = '0;
    for (int a = 0; a < 25; a++) m[a*COEF_W +: COEF_W] = COEF_W'(gauss_coef(a));
    return m;
  endfunction

  // Flat coefficient store. Word (bank*25 + addr) sits at bit offset
  // (bank*25 + addr)*COEF_W.
  logic [MEM_W-1:0] mem_q = mem_init();

  state_e            state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              ksize_q, ksize_d;
  logic [4:0]        idx_q, idx_d;
  logic [2:0]        r_q, r_d;
  logic [2:0]        c_q, c_d;
  logic              valid_q, valid_d;
  logic [COEF_W-1:0] data_q, data_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic              last_q, last_d;
  logic              wr_err_q, wr_err_d;

  logic              hs;
  logic              advance;
  logic              start_acc;
  logic [4:0]        n_len;
  logic [2:0]        dim_m1;
  logic [4:0]        r5, c5, rd_addr;
  logic [AW-1:0]     rd_base, wr_base;
  logic              wr_drop;
  logic              wr_ok;

  assign busy      = (state_q == RUN);
  assign start_acc = (state_q == IDLE) & start;
  assign hs        = valid_q & coef_ready;
  assign n_len     = ksize_q ? 5'd25 : 5'd9;
  assign dim_m1    = ksize_q ? 3'd4 : 3'd2;
  assign advance   = busy & (idx_q < n_len) & (~valid_q | coef_ready);

  // r/c are kernel-relative. The 3x3 window is offset by one row and one
  // column into the 5x5 storage.
  assign r5      = {2'b00, r_q};
  assign c5      = {2'b00, c_q};
  assign rd_addr = ksize_q ? (r5 * 5'd5 + c5) : ((r5 + 5'd1) * 5'd5 + c5 + 5'd1);
  assign rd_base = AW'((int'(bank_q) * 25 + int'(rd_addr)) * COEF_W);
  assign wr_base = AW'((int'(wr_bank) * 25 + int'(wr_addr)) * COEF_W);

  // The bank being streamed is write-protected so the kernel cannot change
  // under the MAC array mid-stream.
  assign wr_drop = (wr_addr > 5'd24) | (busy & (wr_bank == bank_q));
  assign wr_ok   = wr_en & ~wr_drop;

  always_comb begin
    // NOTE: every _d takes its _q value first, so any path that leaves it
    // untouched holds state instead of inferring a latch.
    state_d  = state_q;
    bank_d   = bank_q;
    ksize_d  = ksize_q;
    idx_d    = idx_q;
    r_d      = r_q;
    c_d      = c_q;
    valid_d  = valid_q;
    data_d   = data_q;
    row_d    = row_q;
    col_d    = col_q;
    last_d   = last_q;
    wr_err_d = wr_en & wr_drop;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          bank_d  = rd_bank;
          ksize_d = ksize;
          idx_d   = '0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      RUN: begin
        if (hs && last_q) state_d = IDLE;
        if (advance) begin
          data_d  = mem_q[rd_base +: COEF_W];
          row_d   = r_q;
          col_d   = c_q;
          last_d  = (idx_q == n_len - 5'd1);
          valid_d = 1'b1;
          idx_d   = idx_q + 5'd1;
          if (c_q == dim_m1) begin
            c_d = '0;
            r_d = r_q + 3'd1;
          end else begin
            c_d = c_q + 3'd1;
          end
        end else if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bank_q   <= '0;
      ksize_q  <= 1'b0;
      idx_q    <= '0;
      r_q      <= '0;
      c_q      <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      ksize_q  <= ksize_d;
      idx_q    <= idx_d;
      r_q      <= r_d;
      c_q      <= c_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      row_q    <= row_d;
      col_q    <= col_d;
      last_q   <= last_d;
      wr_err_q <= wr_err_d;
    end
  end

  // NOTE: the store has no reset. Its power-up image comes from the
  // declaration initialiser, and rst_n never disturbs kernel contents.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_base +: COEF_W] <= wr_data;
  end

  assign wr_err     = wr_err_q;
  assign coef_valid = valid_q;
  assign coef_data  = data_q;
  assign coef_row   = row_q;
  assign coef_col   = col_q;
  assign coef_last  = last_q;

`ifdef COEF_SUM_EN
  logic [COEF_W+4:0] sum_q;
  logic              sum_valid_q;

  // The accumulator doubles as the output register. It holds the final sum
  // from the cycle after the last handshake until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= hs & last_q;
      if (start_acc)  sum_q <= '0;
      else if (hs)    sum_q <= sum_q + {5'b00000, data_q};
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
`else
  assign sum_out   = '0;
  assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_coef_bank.sv
// Self-checking bench for kernel_coef_bank. A model of the coefficient store
// produces the expected beat sequence of every stream. The beats are queued
// when start is driven and compared when the output handshake fires. A table
// of stream records covers the main function. Hand-written sequences cover
// back-pressure, write protection and reset mid-stream.
module tb_kernel_coef_bank;
  localparam int COEF_W = 8;
  localparam int NBANK  = 4;
  localparam int BANK_W = $clog2(NBANK);
`ifdef COEF_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  localparam int GAUSS [5][5] = '{'{1, 3, 4, 3, 1}, '{3, 12, 19, 12, 3},
                                  '{4, 19, 32, 19, 4}, '{3, 12, 19, 12, 3},
                                  '{1, 3, 4, 3, 1}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [4:0]        wr_addr;
  logic [COEF_W-1:0] wr_data;
  logic              wr_err;
  logic              start;
  logic [BANK_W-1:0] rd_bank;
  logic              ksize;
  logic              busy;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic [2:0]        coef_row;
  logic [2:0]        coef_col;
  logic              coef_last;
  logic [COEF_W+4:0] sum_out;
  logic              sum_valid;

  always #5 clk = ~clk;

  kernel_coef_bank #(.COEF_W(COEF_W), .NBANK(NBANK)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err),
    .start(start), .rd_bank(rd_bank), .ksize(ksize), .busy(busy),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_row(coef_row), .coef_col(coef_col), .coef_last(coef_last),
    .sum_out(sum_out), .sum_valid(sum_valid)
  );

  typedef struct {
    logic [COEF_W-1:0] data;
    logic [2:0]        row;
    logic [2:0]        col;
    logic              last;
  } beat_t;

  typedef struct {
    int bank;
    bit ks;
    bit stall;
    bit poke;
    int exp_sum;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  beat_t sb_q[$];
  beat_t exp_b;
  int    model [NBANK][25];
  vec_t  vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each output handshake pops and compares one expected beat.
  always @(negedge clk) begin
    if (rst_n && coef_valid && coef_ready) begin
      beats++;
      check("beat_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_b = sb_q.pop_front();
        check("beat_data", coef_data, exp_b.data);
        check("beat_row", coef_row, exp_b.row);
        check("beat_col", coef_col, exp_b.col);
        check("beat_last", coef_last, exp_b.last);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, coef_valid, 0);
    check({tag, "_last"}, coef_last, 0);
    check({tag, "_wr_err"}, wr_err, 0);
    check({tag, "_sum_valid"}, sum_valid, 0);
    check({tag, "_data"}, coef_data, 0);
    check({tag, "_row"}, coef_row, 0);
    check({tag, "_col"}, coef_col, 0);
    check({tag, "_sum_out"}, sum_out, 0);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input int bank, input int addr, input int data, input bit exp_err);
    wr_en   = 1'b1;
    wr_bank = BANK_W'(bank);
    wr_addr = 5'(addr);
    wr_data = COEF_W'(data);
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("wr_err", wr_err, exp_err);
    if (!exp_err) model[bank][addr] = data;
  endtask

  task automatic start_stream(input int bank, input bit ks);
    int dim;
    dim     = ks ? 5 : 3;
    rd_bank = BANK_W'(bank);
    ksize   = ks;
    start   = 1'b1;
    for (int r = 0; r < dim; r++) begin
      for (int c = 0; c < dim; c++) begin
        beat_t b;
        int    a;
        a      = ks ? r * 5 + c : (r + 1) * 5 + c + 1;
        b.data = COEF_W'(model[bank][a]);
        b.row  = 3'(r);
        b.col  = 3'(c);
        b.last = (r == dim - 1) && (c == dim - 1);
        sb_q.push_back(b);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Drains the stream. Optionally uses random back-pressure. With poke set,
  // start is raised in the same cycle as the last handshake; that start must
  // be ignored.
  task automatic finish_stream(input bit stall, input bit poke, input int exp_sum);
    bit done = 1'b0;
    int sum_exp;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      coef_ready = stall ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      start = poke && (sb_q.size() == 1) && coef_valid && coef_last && coef_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (sb_q.size() == 0) done = 1'b1;
    end
    coef_ready = 1'b1;
    sum_exp = SUM_EN ? exp_sum : 0;
    check("stream_done", done, 1);
    check("busy_after_last", busy, 0);
    check("valid_after_last", coef_valid, 0);
    check("sum_valid_pulse", sum_valid, SUM_EN);
    check("sum_out", sum_out, sum_exp);
    @(posedge clk); #1;
    check("sum_valid_drop", sum_valid, 0);
    check("sum_out_hold", sum_out, sum_exp);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int base;
    bit found;

    vecs[0] = '{bank: 0, ks: 1'b1, stall: 1'b0, poke: 1'b0, exp_sum: 200};
    vecs[1] = '{bank: 0, ks: 1'b0, stall: 1'b0, poke: 1'b1, exp_sum: 156};
    vecs[2] = '{bank: 1, ks: 1'b1, stall: 1'b0, poke: 1'b0, exp_sum: 325};
    vecs[3] = '{bank: 1, ks: 1'b0, stall: 1'b1, poke: 1'b0, exp_sum: 117};
    vecs[4] = '{bank: 0, ks: 1'b1, stall: 1'b1, poke: 1'b1, exp_sum: 200};
    vecs[5] = '{bank: 3, ks: 1'b0, stall: 1'b0, poke: 1'b0, exp_sum: 0};

    for (int b = 0; b < NBANK; b++)
      for (int a = 0; a < 25; a++)
        model[b][a] = (b == 0) ? GAUSS[a / 5][a % 5] : 0;

    rst_n = 1'b0; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    start = 1'b0; rd_bank = '0; ksize = 1'b0; coef_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill bank 1 with 1..25, then an out-of-range address must be dropped.
    for (int a = 0; a < 25; a++) do_write(1, a, a + 1, 1'b0);
    do_write(1, 25, 99, 1'b1);
    @(posedge clk); #1;
    check("wr_err_one_cycle", wr_err, 0);

    foreach (vecs[i]) begin
      start_stream(vecs[i].bank, vecs[i].ks);
      finish_stream(vecs[i].stall, vecs[i].poke, vecs[i].exp_sum);
    end

    // Hold coef_ready low for 3 cycles while 19 at (1,2) is presented.
    start_stream(0, 1'b1);
    coef_ready = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      if (coef_valid && coef_row == 3'd1 && coef_col == 3'd2) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("stall_point_found", found, 1);
    coef_ready = 1'b0;
    check("stall_data", coef_data, 19);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_hold_valid", coef_valid, 1);
      check("stall_hold_data", coef_data, 19);
      check("stall_hold_row", coef_row, 1);
      check("stall_hold_col", coef_col, 2);
    end
    finish_stream(1'b0, 1'b0, 200);

    // The streaming bank is write-protected. Another bank is still writable.
    start_stream(0, 1'b1);
    coef_ready = 1'b0;
    do_write(0, 12, 8'hFF, 1'b1);
    do_write(2, 12, 8'h55, 1'b0);
    finish_stream(1'b0, 1'b0, 200);
    start_stream(2, 1'b0);
    finish_stream(1'b0, 1'b0, 85);
    start_stream(0, 1'b0);
    finish_stream(1'b0, 1'b0, 156);

    // Reset after the 10th handshake abandons the stream.
    start_stream(1, 1'b1);
    base = beats;
    for (int cyc = 0; cyc < 100 && (beats - base) < 10; cyc++) begin
      @(posedge clk); #1;
    end
    check("ten_handshakes", beats - base, 10);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_reset_valid", coef_valid, 0);
      check("post_reset_busy", busy, 0);
    end
    start_stream(1, 1'b1);
    finish_stream(1'b0, 1'b0, 325);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
